vga_timing_gen: RTL and testbench
=================================

Name:
vga_timing_gen

Overview:
- Pixel-clock video timing generator. Produces HSync/VSync/DE for a progressive raster (default 1280x720@60, CEA-861 74.25 MHz timing).
- Issues a pixel request with X/Y coordinates one cycle ahead of DE. Registers the returned pixel into an aligned 24-bit RGB output.
- Sits between a frame source (pattern generator / framebuffer reader) and the TMDS/HDMI encoder.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, visible lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- SYNC_POL, 1, sync active level (1 = active-high)

Ports:
- PixelClk  in  1  pixel clock; all logic on rising edge
- RstB  in  1  asynchronous active-low reset
- VideoEn  in  1  timing enable; low = idle, counters held at 0
- VideoDin  in  24  pixel data from source, {R,G,B}; sampled one cycle after VideoReq
- VideoDE  out  1  data enable, aligned with VideoDout
- VideoHS  out  1  horizontal sync
- VideoVS  out  1  vertical sync
- VideoReq  out  1  pixel request, one cycle ahead of VideoDE
- VideoXPos  out  12  column of requested pixel, 0..H_ACTIVE-1, valid while VideoReq=1
- VideoYPos  out  12  row of requested pixel, 0..V_ACTIVE-1, valid while VideoReq=1
- VideoDout  out  24  registered pixel to encoder

Behaviour:
- Clock and reset: one clock (PixelClk); RstB asynchronous, active-low. In reset all registers clear; every output is 0. Syncs are driven inactive (0 when SYNC_POL=1).
- Counters:
  - hcnt runs 0..H_TOTAL-1, with H_TOTAL = sum of the H terms = 1650.
  - vcnt runs 0..V_TOTAL-1, with V_TOTAL = 750; vcnt increments when hcnt wraps.
  - vcnt wraps to 0 after V_TOTAL-1 (frame = 1,237,500 cycles).
- Horizontal regions (hcnt):
  - sync [0, H_SYNC)
  - back porch [H_SYNC, H_SYNC+H_BP)
  - active [260, 1540)
  - front porch [1540, 1650)
- Vertical regions (vcnt), same order: sync 0..4, back porch 5..24, active 25..744, front porch 745..749.
- Stage 1 (registered from counters):
  - VideoReq = h_active AND v_active.
  - VideoXPos = hcnt-260 and VideoYPos = vcnt-25 when VideoReq=1; both 0 otherwise.
  - Internal hs1/vs1 = sync regions.
- Stage 2 (registered from stage 1):
  - VideoDE <= VideoReq; VideoHS <= hs1; VideoVS <= vs1.
  - VideoDout <= VideoReq ? VideoDin : 24'h0.
  - DE/HS/VS/Dout therefore lag VideoReq/XPos/YPos by exactly 1 cycle.
  - The source must drive VideoDin for the requested coordinate before the next rising edge.
- VideoEn:
  - While low, counters are held at 0 and stage 1 forces Req=0, X/Y=0, syncs inactive; outputs reach idle within 2 cycles.
  - On the first edge sampling VideoEn=1, counting starts from (0,0). VideoHS and VideoVS first assert 2 edges later, at the start of frame.
  - Deassertion mid-frame aborts the frame; re-enable always restarts at (0,0).
- VS transitions coincide with HS leading edges (hcnt=0).
- No other handshake: VideoReq is not back-pressured.

Test Plan:
- Reset: hold RstB=0 for 100 cycles with VideoEn=1 -> all outputs 0; release, then VideoHS/VideoVS assert 2 cycles after the first enabled edge.
- Line timing: VideoEn=1, VideoDin=24'hDEADBE -> HS period 1650 cycles, high 40; DE high 1280 consecutive cycles per active line, rising 260 cycles after HS rise.
- Frame timing, over one 1650x750 frame:
  - VS high exactly 8250 cycles.
  - Total DE-high cycles 921,600.
  - First DE line begins 25 lines after VS rise.
- Data path:
  - VideoDout = 24'hDEADBE whenever DE=1 and 0 whenever DE=0.
  - VideoReq rises exactly 1 cycle before DE.
  - X/Y step 0..1279 and 0..719, with the last request at (1279,719).
- Enable control: drop VideoEn mid-line -> within 2 cycles DE=HS=VS=Req=0; re-assert -> frame restarts from (0,0) with identical timing.
- Asynchronous reset mid-frame: assert RstB between clock edges during DE -> outputs clear immediately without waiting for a clock edge; after release, operation resumes from the start of frame.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: video request/data/sync bundle between the timing generator and its source/sink
interface vga_timing_gen_if;
  logic        VideoEn;
  logic [23:0] VideoDin;
  logic        VideoDE;
  logic        VideoHS;
  logic        VideoVS;
  logic        VideoReq;
  logic [11:0] VideoXPos;
  logic [11:0] VideoYPos;
  logic [23:0] VideoDout;
  modport master (
    input  VideoEn, VideoDin,
    output VideoDE, VideoHS, VideoVS, VideoReq, VideoXPos, VideoYPos, VideoDout
  );
  modport slave (
    output VideoEn, VideoDin,
    input  VideoDE, VideoHS, VideoVS, VideoReq, VideoXPos, VideoYPos, VideoDout
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator with one-cycle-ahead pixel request and registered RGB output
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int SYNC_POL = 1
) (
  input  logic             PixelClk,
  input  logic             RstB,
  vga_timing_gen_if.master vid
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam logic SYNC_ON  = SYNC_POL != 0;
  localparam logic SYNC_OFF = ~SYNC_ON;
  logic        run_q, run_d;
  logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        req_q, req_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [23:0] dout_q, dout_d;
  logic        adv, h_wrap, v_wrap, h_act, v_act;
  // Counters advance only from the second enabled edge, so the first enabled edge parks them at (0,0)
  always_comb begin
    adv    = vid.VideoEn && run_q;
    h_wrap = hcnt_q == 12'(H_TOTAL - 1);
    v_wrap = vcnt_q == 12'(V_TOTAL - 1);
    run_d  = vid.VideoEn;
    hcnt_d = (!adv || h_wrap) ? 12'd0 : hcnt_q + 12'd1;
    vcnt_d = !adv ? 12'd0 : !h_wrap ? vcnt_q : v_wrap ? 12'd0 : vcnt_q + 12'd1;
  end
  // Stage 1 decodes the raster position into request, coordinates and raw syncs
  always_comb begin
    h_act  = hcnt_q >= 12'(H_ACT_START) && hcnt_q < 12'(H_ACT_START + H_ACTIVE);
    v_act  = vcnt_q >= 12'(V_ACT_START) && vcnt_q < 12'(V_ACT_START + V_ACTIVE);
    req_d  = adv && h_act && v_act;
    xpos_d = req_d ? hcnt_q - 12'(H_ACT_START) : 12'd0;
    ypos_d = req_d ? vcnt_q - 12'(V_ACT_START) : 12'd0;
    hs1_d  = (adv && hcnt_q < 12'(H_SYNC)) ? SYNC_ON : SYNC_OFF;
    vs1_d  = (adv && vcnt_q < 12'(V_SYNC)) ? SYNC_ON : SYNC_OFF;
  end
  // Stage 2 delays timing by one cycle to line up with the pixel returned by the source
  always_comb begin
    de_d   = req_q;
    hs_d   = hs1_q;
    vs_d   = vs1_q;
    dout_d = req_q ? vid.VideoDin : 24'h0;
  end
  // Pipeline and counter registers; reset parks syncs at their inactive level
  always_ff @(posedge PixelClk or negedge RstB) begin
    if (!RstB) begin
      run_q  <= 1'b0;
      hcnt_q <= 12'd0;
      vcnt_q <= 12'd0;
      req_q  <= 1'b0;
      xpos_q <= 12'd0;
      ypos_q <= 12'd0;
      hs1_q  <= SYNC_OFF;
      vs1_q  <= SYNC_OFF;
      de_q   <= 1'b0;
      hs_q   <= SYNC_OFF;
      vs_q   <= SYNC_OFF;
      dout_q <= 24'h0;
    end else begin
      run_q  <= run_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      req_q  <= req_d;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      dout_q <= dout_d;
    end
  end
  assign vid.VideoReq  = req_q;
  assign vid.VideoXPos = xpos_q;
  assign vid.VideoYPos = ypos_q;
  assign vid.VideoDE   = de_q;
  assign vid.VideoHS   = hs_q;
  assign vid.VideoVS   = vs_q;
  assign vid.VideoDout = dout_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized checks of raster timing and data path against a position-index model
module tb_vga_timing_gen;
  localparam int HA = 16, HFP = 3, HSY = 4, HBP = 5;
  localparam int VA = 6, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  logic clk = 1'b0, rstb = 1'b0;
  int errors = 0, checks = 0;
  int n = 0, np = 0;
  logic [23:0] din_e = 24'h0;
  logic [51:0] obs;
  vga_timing_gen_if vif ();
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1)
  ) dut (
    .PixelClk(clk),
    .RstB(rstb),
    .vid(vif)
  );
  always #5 clk = ~clk;
  assign obs = {vif.VideoReq, vif.VideoXPos, vif.VideoYPos, vif.VideoDE, vif.VideoHS, vif.VideoVS, vif.VideoDout};
  // n counts consecutive enabled edges; request stage shows raster index n-2, output stage the previous one
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      n <= 0;
      np <= 0;
      din_e <= 24'h0;
    end else begin
      np <= n;
      n <= vif.VideoEn ? n + 1 : 0;
      din_e <= vif.VideoDin;
    end
  end
  // Raster index k -> {req, x, y, hs, vs} from the region boundaries
  function automatic logic [26:0] stage(int k, bit ok);
    int h, v;
    logic r;
    if (!ok) return 27'h0;
    h = k % HT;
    v = (k / HT) % VT;
    r = (h >= HSY + HBP) && (h < HSY + HBP + HA) && (v >= VSY + VBP) && (v < VSY + VBP + VA);
    return {r, r ? 12'(h - HSY - HBP) : 12'h0, r ? 12'(v - VSY - VBP) : 12'h0, h < HSY, v < VSY};
  endfunction
  function automatic logic [51:0] expv();
    logic [26:0] s1, s2;
    s1 = stage(n - 2, n >= 2);
    s2 = stage(np - 2, np >= 2);
    return {s1[26:2], s2[26], s2[1], s2[0], s2[26] ? din_e : 24'h0};
  endfunction
  task automatic test_reset();
    rstb = 1'b0;
    vif.VideoEn = 1'b1;
    vif.VideoDin = 24'h123456;
    repeat (100) @(negedge clk);
    checks++;
    if (obs !== 52'h0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    rstb = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if ({vif.VideoHS, vif.VideoVS} !== {2{i == 3}}) begin
        errors++; $display("FAIL sync_start edge=%0d got=%b%b exp=%0d", i, vif.VideoHS, vif.VideoVS, i == 3);
      end
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL reset_model got=%h exp=%h", obs, expv()); end
    end
  endtask
  task automatic test_line_timing();
    int cyc = 0, hs_rise = -1, de_run = 0;
    logic hs_p, de_p;
    vif.VideoDin = 24'hDEADBE;
    hs_p = vif.VideoHS;
    de_p = vif.VideoDE;
    repeat (HT * VT) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL line_model cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
      checks++;
      if (vif.VideoDout !== (vif.VideoDE ? 24'hDEADBE : 24'h0)) begin
        errors++; $display("FAIL dout_value cyc=%0d got=%h de=%b", cyc, vif.VideoDout, vif.VideoDE);
      end
      if (vif.VideoHS && !hs_p) begin
        if (hs_rise >= 0) begin
          checks++;
          if (cyc - hs_rise != HT) begin errors++; $display("FAIL hs_period got=%0d exp=%0d", cyc - hs_rise, HT); end
        end
        hs_rise = cyc;
      end
      if (!vif.VideoHS && hs_p && hs_rise >= 0) begin
        checks++;
        if (cyc - hs_rise != HSY) begin errors++; $display("FAIL hs_width got=%0d exp=%0d", cyc - hs_rise, HSY); end
      end
      if (vif.VideoDE && !de_p && hs_rise >= 0) begin
        checks++;
        if (cyc - hs_rise != HSY + HBP) begin errors++; $display("FAIL de_offset got=%0d exp=%0d", cyc - hs_rise, HSY + HBP); end
      end
      if (!vif.VideoDE && de_p) begin
        checks++;
        if (de_run != HA) begin errors++; $display("FAIL de_run got=%0d exp=%0d", de_run, HA); end
      end
      de_run = vif.VideoDE ? de_run + 1 : 0;
      hs_p = vif.VideoHS;
      de_p = vif.VideoDE;
    end
  endtask
  task automatic test_frame();
    int vs_cnt = 0, de_cnt = 0, vs_rise = -1, de_first = -1;
    logic [11:0] lx = 12'h0, ly = 12'h0;
    logic vs_p = 1'b0, de_p = 1'b0;
    vif.VideoEn = 1'b0;
    repeat (3) @(negedge clk);
    vif.VideoEn = 1'b1;
    for (int i = 1; i <= HT * VT + 2; i++) begin
      @(negedge clk);
      vif.VideoDin = 24'($urandom);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL frame_model i=%0d got=%h exp=%h", i, obs, expv()); end
      if (vif.VideoReq) begin lx = vif.VideoXPos; ly = vif.VideoYPos; end
      if (i >= 3) begin
        vs_cnt += int'(vif.VideoVS);
        de_cnt += int'(vif.VideoDE);
        if (vif.VideoVS && !vs_p && vs_rise < 0) vs_rise = i;
        if (vif.VideoDE && !de_p && de_first < 0) de_first = i;
      end
      vs_p = vif.VideoVS;
      de_p = vif.VideoDE;
    end
    checks++;
    if (vs_cnt != VSY * HT) begin errors++; $display("FAIL vs_high got=%0d exp=%0d", vs_cnt, VSY * HT); end
    checks++;
    if (de_cnt != HA * VA) begin errors++; $display("FAIL de_total got=%0d exp=%0d", de_cnt, HA * VA); end
    checks++;
    if (de_first - vs_rise != (VSY + VBP) * HT + HSY + HBP) begin
      errors++; $display("FAIL first_de_line got=%0d exp=%0d", de_first - vs_rise, (VSY + VBP) * HT + HSY + HBP);
    end
    checks++;
    if (lx != 12'(HA - 1) || ly != 12'(VA - 1)) begin
      errors++; $display("FAIL last_req got=(%0d,%0d) exp=(%0d,%0d)", lx, ly, HA - 1, VA - 1);
    end
  endtask
  task automatic test_enable();
    repeat (3) begin
      repeat ($urandom_range(40, 250)) begin
        @(negedge clk);
        vif.VideoDin = 24'($urandom);
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL en_run_model got=%h exp=%h", obs, expv()); end
      end
      vif.VideoEn = 1'b0;
      repeat (2) begin
        @(negedge clk);
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL en_drop_model got=%h exp=%h", obs, expv()); end
      end
      checks++;
      if ({vif.VideoReq, vif.VideoDE, vif.VideoHS, vif.VideoVS} !== 4'h0) begin
        errors++; $display("FAIL en_idle got=%b%b%b%b exp=0000", vif.VideoReq, vif.VideoDE, vif.VideoHS, vif.VideoVS);
      end
      vif.VideoEn = 1'b1;
      repeat (3 * HT) begin
        @(negedge clk);
        vif.VideoDin = 24'($urandom);
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL en_restart_model got=%h exp=%h", obs, expv()); end
      end
    end
  endtask
  task automatic test_async_reset();
    int w = 0;
    while (!vif.VideoDE && w < 2 * HT * VT) begin
      @(negedge clk);
      vif.VideoDin = 24'($urandom);
      w++;
    end
    checks++;
    if (w >= 2 * HT * VT) begin errors++; $display("FAIL wait_de got=timeout exp=DE"); end
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (obs !== 52'h0) begin errors++; $display("FAIL async_clear got=%h exp=0", obs); end
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (HT * VT / 2) begin
      @(negedge clk);
      vif.VideoDin = 24'($urandom);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL post_reset_model got=%h exp=%h", obs, expv()); end
    end
  endtask
  initial begin
    vif.VideoEn = 1'b0;
    vif.VideoDin = 24'h0;
    test_reset();
    test_line_timing();
    test_frame();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
